uart_rx_byte: RTL

- Receives 8N1 asynchronous serial bytes from the host UART line.
- Delivers each byte to the downstream nonce receiver, with a single-cycle strobe per byte.
- Sits directly upstream of the serial receiver. Its rx_byte_o and new_rx_byte_o drive that block's rx_byte_i and new_rx_byte_i.
- Performs line synchronisation, start-bit validation, mid-bit sampling and stop-bit checking.

---
 rtl/uart_rx_byte_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_byte.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_pkg.sv
// Shared serial definitions for the UART receive path and the serial receiver.
package uart_rx_byte_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned DATA_BITS        = 8;
  localparam logic [7:0]  HEADER_BYTE      = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling, stop check, one-cycle byte strobe.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       new_rx_byte_o,
  output logic       framing_error_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic            rx_s;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            new_q, new_d;
  logic            ferr_q, ferr_d;
  logic            busy_q;

  uart_rx_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  // Next-state, counters and datapath; the counter clears on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    new_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            new_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Held-low line must return high before a new start bit is accepted.
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      new_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      new_q   <= new_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign rx_byte_o       = byte_q;
  assign new_rx_byte_o   = new_q;
  assign framing_error_o = ferr_q;
  assign busy_o          = busy_q;

endmodule
